nand_bist_ctrl: RTL and testbench
=================================

# nand_bist_ctrl

Built-in self-test sequencer for a two-input gate, by default the `nand_gate` cell. On `start` it drives the four input combinations {a,b} = 00, 01, 10, 11 into the gate under test, waits a programmable settle time, samples `y` and compares it against an expected truth table. It reports per-vector failures, an error count, and a pass flag. It sits beside the gate cell and replaces the hand-written stimulus sequence used for gate checks.

## Interface
- `SETTLE_CYCLES`, default 1: cycles a vector is held before its sample edge. Legal range is 1..15.
- `EXPECT`, default 4'b0111: expected `y` for vector index i = {a,b}, held in `EXPECT[i]`. The default is the NAND truth table.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request, sampled only in IDLE.
- `a`  out  1  gate input A (registered).
- `b`  out  1  gate input B (registered).
- `y`  in  1  gate output under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at run completion.
- `pass`  out  1  result of the last completed run; 1 means no mismatches.
- `fail_vec`  out  4  bit i set if vector i mismatched.
- `err_cnt`  out  3  number of mismatching vectors, 0..4.

## Operation
- States are IDLE, SETTLE and SAMPLE. A 2-bit vector index `idx` drives the inputs: `a = idx[1]`, `b = idx[0]`. A settle counter sized for 15 runs alongside.
- **Reset:** state IDLE, `a=b=0`, `busy=0`, `done=0`, `pass=0`, `fail_vec=0`, `err_cnt=0`, `idx=0`, counter 0.
- **IDLE with `start=1`:**
  - Set `idx=0` and `{a,b}=00`.
  - Set `busy=1`.
  - Clear `fail_vec`, `err_cnt` and `pass`.
  - Set counter to 0 and go to SETTLE.
- **SETTLE:**
  - Increment the counter each edge.
  - When the counter equals `SETTLE_CYCLES-1`, go to SAMPLE.
- **SAMPLE:**
  - Compare `y` with `EXPECT[idx]` using 4-state inequality, so X or Z on `y` counts as a mismatch.
  - On mismatch, set `fail_vec[idx]` and increment `err_cnt`.
  - If `idx<3`: increment `idx`, drive the next vector, set counter to 0, go to SETTLE.
  - If `idx==3`: go to IDLE with `busy=0`, `done=1`, `pass` = (final `err_cnt`==0), and `{a,b}=00`.
- **Outside a run:** `done` clears on the next edge. `pass`, `fail_vec` and `err_cnt` hold until the next accepted `start` or `rst`.
- **`start` while not IDLE:** ignored, with no queuing. This includes the final SAMPLE edge.
- **`rst` mid-run:** the run is abandoned and all outputs take their reset values. No `done` pulse is issued.
- **Back-to-back runs:** `start` held high re-launches a run on the first edge after completion, i.e. the edge following the `done` edge.

## Timing
- Let t0 be the edge at which `start` is accepted. Each vector occupies `SETTLE_CYCLES+1` cycles.
- Vector i is driven from edge t0+i·(S+1) and sampled at edge t0+(i+1)·(S+1), where S=`SETTLE_CYCLES`.
- `done` rises after edge t0+4·(S+1) and stays high for exactly one cycle. With S=1, that is edge t0+8.
- `busy` rises after t0 and falls together with the `done` rise.
- `a` and `b` change only on edges: t0 and each non-final SAMPLE edge.
- `y` must be stable by the sample edge. The combinational gate is settled after one cycle.

## Configuration
- Macro: `NAND_BIST_ABORT_EN`.
- **Defined:** a mismatch in SAMPLE ends the run immediately, with the same completion actions as `idx==3`. The remaining `fail_vec` bits stay 0, `err_cnt=1`, and `pass=0`.
- **Undefined:** all four vectors are always applied, regardless of mismatches.
- Ports and reset behaviour are identical in both builds.

## Test plan
- Real `nand_gate`, S=1, `start` at t0 -> `{a,b}` sequence is 00,01,10,11 at two-cycle spacing. `done` rises at t0+8 with `pass=1`, `fail_vec=0000`, `err_cnt=0`.
- `y` stuck at 1 -> `fail_vec=1000`, `err_cnt=1`, `pass=0`.
- `y` stuck at 0:
  - Without the macro: `fail_vec=0111`, `err_cnt=3`, `done` at t0+8.
  - With `NAND_BIST_ABORT_EN`: `fail_vec=0001`, `err_cnt=1`, `done` at t0+2.
- S=3, real gate -> each vector is held 4 cycles and `done` rises at t0+16. A `start` pulse at t0+5 is ignored, and no second run occurs.
- `rst` asserted at t0+5 -> the next edge gives `a=b=0`, `busy=0`, `pass=0`, `fail_vec=0`, and no `done`. A subsequent `start` runs normally and passes.
- `y` driven X on vector 2 -> `fail_vec=0100`, `err_cnt=1`, `pass=0`.

Source files
------------

// File: rtl/nand_bist_ctrl.sv
// ---------------------------------------------------------------------------
// nand_bist_ctrl
//
// Built-in self-test sequencer for a two-input gate (NAND by default). On an
// accepted start it drives {a,b} = 00, 01, 10, 11, holds each vector for
// SETTLE_CYCLES cycles, then samples y on the following edge and compares it
// with EXPECT[{a,b}]. Per-vector mismatches, a mismatch count and a pass flag
// are reported and held until the next accepted start or reset.
//
// Parameters
//   SETTLE_CYCLES  cycles a vector is held before its sample edge (1..15)
//   EXPECT         expected y per vector index {a,b}; default is NAND
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   run request, only honoured in IDLE
//   a, b      out  registered gate inputs
//   y         in   gate output under test
//   busy      out  high while a run is in progress
//   done      out  one-cycle pulse when a run completes
//   pass      out  1 when the last completed run had no mismatches
//   fail_vec  out  bit i set when vector i mismatched
//   err_cnt   out  number of mismatching vectors (0..4)
//
// Build option
//   NAND_BIST_ABORT_EN  when defined, the first mismatch ends the run at once
//                       with the normal completion actions.
// ---------------------------------------------------------------------------
module nand_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXPECT        = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [2:0] err_cnt_q, err_cnt_d;

  // Case inequality so that an X or Z on the gate output is a failure.
  logic       mismatch;
  assign mismatch = (y !== EXPECT[idx_q]);

  logic [1:0] idx_next;
  assign idx_next = idx_q + 2'd1;

  logic       last_vec;
`ifdef NAND_BIST_ABORT_EN
  assign last_vec = (idx_q == 2'd3) || mismatch;
`else
  assign last_vec = (idx_q == 2'd3);
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case can leave one unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d      = 2'd0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          busy_d     = 1'b1;
          fail_vec_d = 4'b0000;
          err_cnt_d  = 3'd0;
          pass_d     = 1'b0;
          cnt_d      = 4'd0;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          fail_vec_d[idx_q] = 1'b1;
          err_cnt_d         = err_cnt_q + 3'd1;
        end
        if (last_vec) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 3'd0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          idx_d   = idx_next;
          a_d     = idx_next[1];
          b_d     = idx_next[0];
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= 4'b0000;
      err_cnt_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_vec_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_nand_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nand_bist_ctrl
//
// Two controllers share one bench: dut1 with SETTLE_CYCLES=1 and dut3 with
// SETTLE_CYCLES=3. Each drives a behavioural gate whose fault mode is chosen
// per scenario. Expected results are pushed to a scoreboard when a run is
// launched and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_nand_bist_ctrl;

  typedef enum logic [1:0] {Y_GOOD, Y_STUCK1, Y_STUCK0, Y_X2} ymode_t;

  typedef struct {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  ymode_t mode = Y_GOOD;
  logic y_xval = 1'bx;
  logic [3:0] exp_tt = 4'b0111;

  logic       start1, start3;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic       a3, b3, y3, busy3, done3, pass3;
  logic [3:0] fv1, fv3;
  logic [2:0] ec1, ec3;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  function automatic logic gate(input ymode_t m, input logic xv,
                                input logic aa, input logic bb);
    case (m)
      Y_STUCK1: return 1'b1;
      Y_STUCK0: return 1'b0;
      Y_X2:     return (aa && !bb) ? xv : ~(aa & bb);
      default:  return ~(aa & bb);
    endcase
  endfunction

  always_comb y1 = gate(mode, y_xval, a1, b1);
  always_comb y3 = gate(mode, y_xval, a3, b3);

  nand_bist_ctrl #(.SETTLE_CYCLES(1), .EXPECT(4'b0111)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1), .err_cnt(ec1)
  );

  nand_bist_ctrl #(.SETTLE_CYCLES(3), .EXPECT(4'b0111)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_vec(fv3), .err_cnt(ec3)
  );

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_fv;
  logic [2:0] o_ec;
  assign o_a    = sel ? a3    : a1;
  assign o_b    = sel ? b3    : b1;
  assign o_busy = sel ? busy3 : busy1;
  assign o_done = sel ? done3 : done1;
  assign o_pass = sel ? pass3 : pass1;
  assign o_fv   = sel ? fv3   : fv1;
  assign o_ec   = sel ? ec3   : ec1;

  // Launch nruns runs (start held high across completions when nruns > 1)
  // and check {a,b,busy,done} every cycle from t0 onward. extra_k / rst_k
  // give the edge offset from t0 at which a stray start or a reset is
  // sampled (-1 for none).
  task automatic run(input string name, input logic sel_i, input int s,
                     input ymode_t m, input int nruns, input int extra_k,
                     input int rst_k);
    exp_t e;
    int dk;
    bit aborted;
    bit rst_hit;
    logic [3:0] exp_obs;
    logic [3:0] obs;
    logic yv;
    int r, kk, v;

    e.fv = 4'b0000;
    e.ec = 3'd0;
    dk = 4 * (s + 1);
    aborted = 1'b0;
    for (int i = 0; i < 4; i++) begin
      yv = gate(m, y_xval, i[1], i[0]);
      if (!aborted && (yv !== exp_tt[i])) begin
        e.fv[i] = 1'b1;
        e.ec    = e.ec + 3'd1;
`ifdef NAND_BIST_ABORT_EN
        aborted = 1'b1;
        dk = (i + 1) * (s + 1);
`endif
      end
    end
    e.pass = (e.ec == 3'd0);
    for (int n = 0; n < nruns; n++) sb.push_back(e);

    @(negedge clk);
    sel = sel_i;
    mode = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = (nruns > 1);
    rst_hit = 1'b0;

    for (int k = 0; k <= nruns * (dk + 1) + 2; k++) begin
      @(negedge clk);
      if (k == rst_k) rst_hit = 1'b1;
      r  = k / (dk + 1);
      kk = k % (dk + 1);
      if (rst_hit || r >= nruns) begin
        exp_obs = 4'b0000;
      end else if (kk < dk) begin
        v = kk / (s + 1);
        exp_obs = {v[1], v[0], 1'b1, 1'b0};
      end else begin
        exp_obs = 4'b0001;
      end
      obs = {o_a, o_b, o_busy, o_done};
      n_checks++;
      if (obs !== exp_obs) begin
        n_errors++;
        $display("FAIL %s cyc t0+%0d {a,b,busy,done}: got %b want %b",
                 name, k, obs, exp_obs);
      end

      if (!rst_hit && r < nruns && kk == dk) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL %s scoreboard empty at done", name);
        end else begin
          e = sb.pop_front();
          if ({o_fv, o_ec, o_pass} !== {e.fv, e.ec, e.pass}) begin
            n_errors++;
            $display("FAIL %s result fv/ec/pass: got %b/%0d/%b want %b/%0d/%b",
                     name, o_fv, o_ec, o_pass, e.fv, e.ec, e.pass);
          end
        end
      end

      if (rst_hit && k == rst_k) begin
        n_checks++;
        if ({o_fv, o_ec, o_pass} !== 8'h00) begin
          n_errors++;
          $display("FAIL %s reset results fv/ec/pass: got %b/%0d/%b want 0000/0/0",
                   name, o_fv, o_ec, o_pass);
        end
        while (sb.size() > 0) void'(sb.pop_front());
      end

      start = (k < (nruns - 1) * (dk + 1)) || (k == extra_k - 1);
      rst   = (k == rst_k - 1);
    end
    start = 1'b0;
    rst   = 1'b0;

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s scoreboard leftover: got %0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a1, b1, busy1, done1, pass1, fv1, ec1} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset dut1 {a,b,busy,done,pass,fv,ec}: got %b want 0",
               {a1, b1, busy1, done1, pass1, fv1, ec1});
    end
    n_checks++;
    if ({a3, b3, busy3, done3, pass3, fv3, ec3} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset dut3 {a,b,busy,done,pass,fv,ec}: got %b want 0",
               {a3, b3, busy3, done3, pass3, fv3, ec3});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_gate();
    run("good_s1", 1'b0, 1, Y_GOOD, 1, -1, -1);
  endtask

  task automatic test_stuck1();
    run("stuck1", 1'b0, 1, Y_STUCK1, 1, -1, -1);
  endtask

  task automatic test_stuck0();
    run("stuck0", 1'b0, 1, Y_STUCK0, 1, -1, -1);
  endtask

  task automatic test_settle3();
    run("good_s3_stray_start", 1'b1, 3, Y_GOOD, 1, 5, -1);
  endtask

  task automatic test_rst_mid_run();
    run("rst_mid_run", 1'b0, 1, Y_GOOD, 1, -1, 5);
    run("after_rst", 1'b0, 1, Y_GOOD, 1, -1, -1);
  endtask

  task automatic test_x_vec2();
    run("x_on_vec2", 1'b0, 1, Y_X2, 1, -1, -1);
  endtask

  task automatic test_back_to_back();
    run("back_to_back", 1'b0, 1, Y_GOOD, 2, -1, -1);
  endtask

  initial begin
    test_reset();
    test_good_gate();
    test_stuck1();
    test_stuck0();
    test_settle3();
    test_rst_mid_run();
    test_x_vec2();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
